// File: rtl/puf_pkg.sv
// Shared types, defaults and helpers for the ring-oscillator PUF measurement path.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } puf_state_t;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_WINDOW_CYC = 1024;

    // A challenge pair is usable only if it names two distinct, existing oscillators.
    function automatic logic sel_legal(input int a, input int b, input int n);
        return (a != b) && (a < n) && (b < n);
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Two-flop synchronizer, rising-edge detector and saturating edge counter for one
// asynchronous ring-oscillator output.
module ro_edge_counter
    import puf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             ro_in,
    output logic [CNT_W-1:0] cnt
);

    // [0],[1] form the synchronizer, [2] holds the previous synchronized level.
    logic [2:0] sync_reg;
    logic       rise;

    assign rise = sync_reg[1] & ~sync_reg[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            cnt      <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], ro_in};
            if (clr) begin
                cnt <= '0;
            end else if (cnt_en && rise && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ro_puf_reader.sv
// Ring-oscillator PUF reader: enables a challenge-selected RO pair, counts edges over a
// fixed window and returns one response bit. Optional raw-count outputs: PUF_RAW_COUNT_EN.
module ro_puf_reader
    import puf_pkg::*;
#(
    parameter int N_RO       = 16,
    parameter int SEL_W      = $clog2(N_RO),
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WINDOW_CYC = DEF_WINDOW_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    output logic [N_RO-1:0]  ro_en,
    input  logic [N_RO-1:0]  ro_in,
    output logic             busy,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_bit,
    output logic             resp_tie,
    output logic             resp_err
`ifdef PUF_RAW_COUNT_EN
    ,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
`endif
);

    localparam int TMR_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    puf_state_t       state_reg;
    logic [TMR_W-1:0] tmr_reg;
    logic [SEL_W-1:0] sel_a_reg;
    logic [SEL_W-1:0] sel_b_reg;
    logic             err_reg;
    logic [N_RO-1:0]  en_pattern;
    logic             legal;
    logic             accept;
    logic             clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    assign legal  = sel_legal(int'(sel_a), int'(sel_b), N_RO);
    assign accept = (state_reg == IDLE) && start && legal;
    // Clearing on acceptance and throughout SETTLE keeps counters at 0 until the window opens.
    assign clr    = accept || (state_reg == SETTLE);
    assign cnt_en = (state_reg == COUNT);

    for (genvar gi = 0; gi < N_RO; gi++) begin : g_en
        assign en_pattern[gi] = (sel_a == SEL_W'(gi)) || (sel_b == SEL_W'(gi));
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .cnt_en (cnt_en),
        .ro_in  (ro_in[sel_a_reg]),
        .cnt    (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .cnt_en (cnt_en),
        .ro_in  (ro_in[sel_b_reg]),
        .cnt    (cnt_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            tmr_reg    <= '0;
            sel_a_reg  <= '0;
            sel_b_reg  <= '0;
            err_reg    <= 1'b0;
            ro_en      <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_bit   <= 1'b0;
            resp_tie   <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        resp_bit <= 1'b0;
                        resp_tie <= 1'b0;
                        resp_err <= 1'b0;
                        if (legal) begin
                            sel_a_reg <= sel_a;
                            sel_b_reg <= sel_b;
                            err_reg   <= 1'b0;
                            ro_en     <= en_pattern;
                            tmr_reg   <= TMR_W'(SETTLE_CYC - 1);
                            state_reg <= SETTLE;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (tmr_reg == '0) begin
                        tmr_reg   <= TMR_W'(WINDOW_CYC - 1);
                        state_reg <= COUNT;
                    end else begin
                        tmr_reg <= tmr_reg - 1'b1;
                    end
                end
                COUNT: begin
                    if (tmr_reg == '0) begin
                        ro_en     <= '0;
                        state_reg <= DONE;
                    end else begin
                        tmr_reg <= tmr_reg - 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle compares the final counts, which include the last window edge.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= err_reg;
                        resp_bit   <= !err_reg && (cnt_a > cnt_b);
                        resp_tie   <= !err_reg && (cnt_a == cnt_b);
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef PUF_RAW_COUNT_EN
    assign count_a = cnt_a;
    assign count_b = cnt_b;
`endif

endmodule

// File: tb/tb_ro_puf_reader.sv
// Randomized bench for ro_puf_reader: square-wave RO models, recorded sample history and
// a counting reference model; raw counts are checked when PUF_RAW_COUNT_EN is defined.
module tb_ro_puf_reader;

    localparam int N_RO   = 12;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 6;
    localparam int SETTLE = 8;
    localparam int WIN    = 300;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [SEL_W-1:0] sel_a = '0;
    logic [SEL_W-1:0] sel_b = '0;
    logic [N_RO-1:0]  ro_en;
    logic [N_RO-1:0]  ro_in = '0;
    logic             busy;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_bit;
    logic             resp_tie;
    logic             resp_err;
`ifdef PUF_RAW_COUNT_EN
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;
`endif

    int errors = 0;
    int checks = 0;
    int txn_id = 0;
    int edge_n = 0;
    int per [N_RO] = '{default: 4};
    int ph  [N_RO] = '{default: 0};
    logic [N_RO-1:0] hist [0:32767];

    ro_puf_reader #(
        .N_RO       (N_RO),
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE),
        .WINDOW_CYC (WIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .ro_en      (ro_en),
        .ro_in      (ro_in),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_bit   (resp_bit),
        .resp_tie   (resp_tie),
        .resp_err   (resp_err)
`ifdef PUF_RAW_COUNT_EN
        ,
        .count_a    (count_a),
        .count_b    (count_b)
`endif
    );

    always #5 clk = ~clk;

    // Record what the DUT samples at every rising edge.
    always @(posedge clk) begin
        hist[edge_n] = ro_in;
        edge_n = edge_n + 1;
    end

    // Square-wave oscillators, changing away from the sampling edge.
    always @(negedge clk) begin
        for (int i = 0; i < N_RO; i++) begin
            ro_in[i] = ((edge_n + ph[i]) % per[i]) < (per[i] / 2);
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Rising edges of one oscillator inside the counting window, saturated. A sample taken at
    // edge k passes two synchronizer stages and is counted only while the window is open,
    // so the counted samples span SETTLE-1 .. SETTLE+WIN-2 edges after the accepting edge.
    function automatic int model_count(input int sel, input int acc);
        int r = 0;
        for (int k = acc + SETTLE - 1; k <= acc + SETTLE + WIN - 2; k++) begin
            if (hist[k][sel] && !hist[k-1][sel]) r++;
        end
        return (r > MAXC) ? MAXC : r;
    endfunction

    task automatic randomize_waves();
        for (int i = 0; i < N_RO; i++) begin
            per[i] = $urandom_range(14, 4);
            ph[i]  = $urandom_range(per[i] - 1, 0);
        end
    endtask

    task automatic run_txn(input int a, input int b, input int pa, input int pha,
                           input int pb, input int phb, input int hold, input bit poke);
        int acc;
        int waited;
        int lat;
        int ca;
        int cb;
        bit legal;
        bit eb;
        bit et;
        logic [N_RO-1:0] pat;
        logic [63:0] hold_exp;
        randomize_waves();
        if (pa > 0 && a < N_RO) begin per[a] = pa; ph[a] = pha; end
        if (pb > 0 && b < N_RO) begin per[b] = pb; ph[b] = phb; end
        legal = (a != b) && (a < N_RO) && (b < N_RO);
        pat = '0;
        if (legal) begin
            pat[a] = 1'b1;
            pat[b] = 1'b1;
        end
        @(negedge clk);
        start = 1'b1;
        sel_a = SEL_W'(a);
        sel_b = SEL_W'(b);
        acc   = edge_n;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'(1));
        check_eq("ro_en_pattern", 64'(ro_en), 64'(pat));
        waited = 0;
        while (!resp_valid && waited < SETTLE + WIN + 20) begin
            @(negedge clk);
            waited++;
        end
        if (!resp_valid) begin
            check_eq("resp_valid_timeout", 64'(resp_valid), 64'(1));
            return;
        end
        lat = edge_n - acc;
        check_eq("latency", 64'(lat), legal ? 64'(1 + SETTLE + WIN + 1) : 64'(2));
        ca = legal ? model_count(a, acc) : 0;
        cb = legal ? model_count(b, acc) : 0;
        eb = legal && (ca > cb);
        et = legal && (ca == cb);
        check_eq("resp_err", 64'(resp_err), 64'(!legal));
        check_eq("resp_bit", 64'(resp_bit), 64'(eb));
        check_eq("resp_tie", 64'(resp_tie), 64'(et));
        check_eq("ro_en_done", 64'(ro_en), 64'(0));
`ifdef PUF_RAW_COUNT_EN
        if (legal) begin
            check_eq("count_a", 64'(count_a), 64'(ca));
            check_eq("count_b", 64'(count_b), 64'(cb));
        end
`endif
        hold_exp = {58'd0, 1'b1, 1'b1, eb, et, !legal, 1'b1};
        for (int i = 0; i < hold; i++) begin
            if (poke) start = (i == hold / 2);
            sel_a = SEL_W'($urandom_range(N_RO - 1, 0));
            sel_b = SEL_W'($urandom_range(N_RO - 1, 0));
            @(negedge clk);
            check_eq("hold_stable",
                     {58'd0, resp_valid, busy, resp_bit, resp_tie, resp_err, ro_en == '0},
                     hold_exp);
        end
        start = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("consumed_valid", 64'(resp_valid), 64'(0));
        check_eq("consumed_busy", 64'(busy), 64'(0));
        $display("txn %0d sel=%0d/%0d per=%0d/%0d cnt=%0d/%0d lat=%0d bit=%0d tie=%0d err=%0d",
                 txn_id, a, b, (a < N_RO) ? per[a] : 0, (b < N_RO) ? per[b] : 0,
                 ca, cb, lat, resp_bit, resp_tie, resp_err);
        txn_id++;
    endtask

    task automatic abort_txn();
        randomize_waves();
        @(negedge clk);
        start = 1'b1;
        sel_a = 4'd2;
        sel_b = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 100) @(negedge clk);
        check_eq("pre_abort_ro_en", 64'(ro_en), 64'(12'h204));
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_ro_en", 64'(ro_en), 64'(0));
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_valid", 64'(resp_valid), 64'(0));
`ifdef PUF_RAW_COUNT_EN
        check_eq("abort_count_a", 64'(count_a), 64'(0));
`endif
        rst = 1'b0;
        $display("txn %0d abort mid-count sel=2/9 ro_en=%0h busy=%0d", txn_id, ro_en, busy);
        txn_id++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_ro_en", 64'(ro_en), 64'(0));
        check_eq("reset_busy", 64'(busy), 64'(0));
        check_eq("reset_valid", 64'(resp_valid), 64'(0));
        check_eq("reset_outs", {61'd0, resp_bit, resp_tie, resp_err}, 64'(0));
`ifdef PUF_RAW_COUNT_EN
        check_eq("reset_counts", {52'd0, count_a, count_b}, 64'(0));
`endif
        rst = 1'b0;
        @(negedge clk);
        run_txn(3, 7, 10, 0, 12, 0, 0, 1'b0);    // A faster than B
        run_txn(1, 2, 10, 3, 10, 3, 0, 1'b0);    // identical waves -> tie
        run_txn(5, 5, 0, 0, 0, 0, 0, 1'b0);      // same index
        run_txn(12, 3, 0, 0, 0, 0, 0, 1'b0);     // out of range A
        run_txn(0, 15, 0, 0, 0, 0, 0, 1'b0);     // out of range B
        run_txn(0, 11, 4, 0, 4, 1, 0, 1'b0);     // both saturate -> tie
        run_txn(6, 4, 4, 2, 13, 5, 0, 1'b0);     // A saturates, B slower
        run_txn(8, 10, 12, 0, 10, 0, 50, 1'b1);  // long hold with ignored start
        abort_txn();
        run_txn(9, 2, 10, 1, 12, 4, 0, 1'b0);    // full latency after abort
        for (int t = 0; t < 16; t++) begin
            int a;
            int b;
            a = $urandom_range(15, 0);
            b = ($urandom_range(7, 0) == 0) ? a : $urandom_range(N_RO - 1, 0);
            run_txn(a, b, 0, 0, 0, 0, $urandom_range(4, 0), 1'b1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
